am_demod_arbiter: RTL and testbench

Time-shares one `am_demod` magnitude pipeline among `NUM_CH` receiver channels. Each channel's I/Q sample is captured into a one-entry holding buffer. A round-robin scheduler issues at most one sample per clock to the demodulator. A fixed-latency tag pipeline routes each result back to its originating channel. The block sits between the per-channel decimation filters and the per-channel audio/AGC stages.

---
 rtl/am_demod_arbiter.sv | 164 ++++++++++++++++
 tb/tb_am_demod_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_demod_arbiter.sv
// am_demod_arbiter: shares one am_demod magnitude pipeline among NUM_CH
// channels. Each channel has a one-entry holding buffer, a round-robin
// scheduler issues at most one sample per clock, and a fixed-latency tag
// pipeline steers every demodulator result back to the channel it came from.
module am_demod_arbiter #(
    parameter int DATA_SIZE = 16,
    parameter int NUM_CH    = 4,
    parameter int LATENCY   = 3,
    parameter int TAG_W     = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           ch_strobe,
    input  logic [NUM_CH*DATA_SIZE-1:0] ch_i,
    input  logic [NUM_CH*DATA_SIZE-1:0] ch_q,
    output logic                        dm_strobe,
    output logic [DATA_SIZE-1:0]        dm_i,
    output logic [DATA_SIZE-1:0]        dm_q,
    input  logic                        dm_strobe_in,
    input  logic [DATA_SIZE-1:0]        dm_data,
    output logic [NUM_CH-1:0]           out_strobe,
    output logic [DATA_SIZE-1:0]        out_data,
    output logic [NUM_CH-1:0]           overrun,
    output logic                        sync_err,
    input  logic                        flag_clr
);

    // Holding buffers
    logic [NUM_CH-1:0]    pend_v;
    logic [DATA_SIZE-1:0] pend_i [NUM_CH];
    logic [DATA_SIZE-1:0] pend_q [NUM_CH];

    // Scheduler
    logic [TAG_W-1:0]     rr_ptr;
    logic [TAG_W-1:0]     dm_tag;
    logic [TAG_W-1:0]     cand;
    logic                 gnt_v;
    logic [TAG_W-1:0]     gnt_idx;
    logic [NUM_CH-1:0]    gnt_oh;
    logic [NUM_CH-1:0]    ovr_set;

    // Tag pipeline, stage LATENCY-1 lines up with dm_strobe_in
    logic [LATENCY-1:0]   tp_v;
    logic [TAG_W-1:0]     tp_tag [LATENCY];
    logic                 tail_v;
    logic [TAG_W-1:0]     tail_tag;
    logic                 route;
    logic [NUM_CH-1:0]    route_oh;

    assign tail_v   = tp_v[LATENCY-1];
    assign tail_tag = tp_tag[LATENCY-1];
    assign route    = dm_strobe_in & tail_v;

    // Round-robin search of pend_v starting at rr_ptr; first pending channel wins
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path infers a latch.
        gnt_v   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        gnt_oh  = '0;
        ovr_set = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            cand = TAG_W'((int'(rr_ptr) + off) % NUM_CH);
            if (!gnt_v && pend_v[cand]) begin
                gnt_v   = 1'b1;
                gnt_idx = cand;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            gnt_oh[k]  = gnt_v && (gnt_idx == TAG_W'(k));
            ovr_set[k] = ch_strobe[k] && pend_v[k] && !gnt_oh[k];
        end
    end

    // One-hot decode of the tail tag for result routing
    always_comb begin
        route_oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            route_oh[k] = (tail_tag == TAG_W'(k));
        end
    end

    // Pending flags: a new strobe always wins over a grant in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            pend_v <= '0;
        end else begin
            pend_v <= ch_strobe | (pend_v & ~gnt_oh);
        end
    end

    // Sample capture; newest sample always overwrites the buffer
    always_ff @(posedge clk) begin
        // NOTE: the data buffers have no reset; pend_v alone says whether they hold a live sample.
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_strobe[k]) begin
                pend_i[k] <= ch_i[k*DATA_SIZE +: DATA_SIZE];
                pend_q[k] <= ch_q[k*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Issue stage: register the winner towards the demodulator and advance rr_ptr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dm_strobe <= 1'b0;
            dm_i      <= '0;
            dm_q      <= '0;
            dm_tag    <= '0;
            rr_ptr    <= '0;
        end else begin
            dm_strobe <= gnt_v;
            if (gnt_v) begin
                dm_i   <= pend_i[gnt_idx];
                dm_q   <= pend_q[gnt_idx];
                dm_tag <= gnt_idx;
                rr_ptr <= (gnt_idx == TAG_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Tag pipeline tracking which channel each in-flight sample belongs to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tp_v <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tp_tag[s] <= '0;
            end
        end else begin
            tp_v[0]   <= dm_strobe;
            tp_tag[0] <= dm_tag;
            for (int s = 1; s < LATENCY; s++) begin
                tp_v[s]   <= tp_v[s-1];
                tp_tag[s] <= tp_tag[s-1];
            end
        end
    end

    // Result routing: one-cycle one-hot strobe with the demodulator word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_strobe <= '0;
            out_data   <= '0;
        end else begin
            out_strobe <= route ? route_oh : '0;
            if (route) begin
                out_data <= dm_data;
            end
        end
    end

    // Sticky status flags; a set in the same cycle beats flag_clr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun  <= '0;
            sync_err <= 1'b0;
        end else begin
            overrun  <= (overrun & ~{NUM_CH{flag_clr}}) | ovr_set;
            sync_err <= (sync_err & ~flag_clr) | (tail_v != dm_strobe_in);
        end
    end

endmodule

// File: tb/tb_am_demod_arbiter.sv
// Testbench for am_demod_arbiter: a behavioural demodulator stub plus a
// transaction-level reference model (pending table, round-robin pointer and
// a queue of expected results) checked every cycle, then directed cases for
// reset, overrun clearing and sync errors.
module tb_am_demod_arbiter;

    localparam int DS  = 16;
    localparam int NCH = 4;
    localparam int LAT = 3;
    localparam int TW  = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    ch_strobe;
    logic [NCH*DS-1:0] ch_i;
    logic [NCH*DS-1:0] ch_q;
    logic              dm_strobe;
    logic [DS-1:0]     dm_i;
    logic [DS-1:0]     dm_q;
    logic              dm_strobe_in;
    logic [DS-1:0]     dm_data;
    logic [NCH-1:0]    out_strobe;
    logic [DS-1:0]     out_data;
    logic [NCH-1:0]    overrun;
    logic              sync_err;
    logic              flag_clr;

    logic              inj_en;
    logic              drop_en;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit model_on;

    am_demod_arbiter #(.DATA_SIZE(DS), .NUM_CH(NCH), .LATENCY(LAT), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .ch_strobe(ch_strobe), .ch_i(ch_i), .ch_q(ch_q),
        .dm_strobe(dm_strobe), .dm_i(dm_i), .dm_q(dm_q),
        .dm_strobe_in(dm_strobe_in), .dm_data(dm_data),
        .out_strobe(out_strobe), .out_data(out_data),
        .overrun(overrun), .sync_err(sync_err), .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    // Magnitude floor(sqrt(I^2 + Q^2)) of signed I/Q
    function automatic logic [DS-1:0] mag(input logic [DS-1:0] i, input logic [DS-1:0] q);
        longint si, sq, p, r, t;
        si = longint'($signed(i));
        sq = longint'($signed(q));
        p  = si * si + sq * sq;
        r  = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r + (longint'(1) << b);
            if (t * t <= p) r = t;
        end
        return DS'(r);
    endfunction

    // Behavioural demodulator: LAT-cycle pipeline, with fault injection hooks
    logic [LAT-1:0] d_v;
    logic [DS-1:0]  d_d [LAT];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_v <= '0;
            for (int s = 0; s < LAT; s++) d_d[s] <= '0;
        end else begin
            d_v[0] <= dm_strobe;
            d_d[0] <= mag(dm_i, dm_q);
            for (int s = 1; s < LAT; s++) begin
                d_v[s] <= d_v[s-1];
                d_d[s] <= d_d[s-1];
            end
        end
    end
    assign dm_strobe_in = (d_v[LAT-1] & ~drop_en) | inj_en;
    assign dm_data      = d_d[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            ch;
        logic [DS-1:0] data;
    } exp_t;

    exp_t           exp_q[$];
    int             start_q [NCH][$];
    bit             m_pend [NCH];
    logic [DS-1:0]  m_i [NCH];
    logic [DS-1:0]  m_q [NCH];
    int             m_ptr;
    logic [NCH-1:0] m_ovr;
    logic           e_dm_v;
    logic [DS-1:0]  e_dm_i, e_dm_q;
    int             grants [NCH];
    int             out_cnt [NCH];
    int             max_wait;

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_pend[k] = 0;
            start_q[k].delete();
        end
        exp_q.delete();
        m_ptr  = 0;
        m_ovr  = '0;
        e_dm_v = 1'b0;
        e_dm_i = '0;
        e_dm_q = '0;
    endtask

    // One clock edge of the specified behaviour, seen as transactions
    task automatic model_edge();
        bit             gv;
        int             g;
        logic [NCH-1:0] set;
        gv = 0;
        g  = 0;
        for (int off = 0; off < NCH; off++) begin
            int idx;
            idx = (m_ptr + off) % NCH;
            if (!gv && m_pend[idx]) begin
                gv = 1;
                g  = idx;
            end
        end
        if (gv) begin
            exp_q.push_back('{cyc + 4, g, mag(m_i[g], m_q[g])});
            e_dm_v = 1'b1;
            e_dm_i = m_i[g];
            e_dm_q = m_q[g];
            m_ptr  = (g + 1) % NCH;
            grants[g]++;
        end else begin
            e_dm_v = 1'b0;
        end
        set = '0;
        for (int k = 0; k < NCH; k++) begin
            bit won;
            won = gv && (g == k);
            if (ch_strobe[k]) begin
                if (m_pend[k] && !won) set[k] = 1'b1;
                if (!m_pend[k] || won) start_q[k].push_back(cyc);
                m_i[k]    = ch_i[k*DS +: DS];
                m_q[k]    = ch_q[k*DS +: DS];
                m_pend[k] = 1;
            end else if (won) begin
                m_pend[k] = 0;
            end
        end
        m_ovr = (m_ovr & ~{NCH{flag_clr}}) | set;
    endtask

    task automatic compare_all();
        logic [NCH-1:0] eo;
        logic [DS-1:0]  ed;
        eo = '0;
        ed = '0;
        check("dm_strobe", dm_strobe, e_dm_v);
        check("dm_iq", {dm_i, dm_q}, {e_dm_i, e_dm_q});
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e  = exp_q.pop_front();
            eo = NCH'(1) << e.ch;
            ed = e.data;
        end
        check("out_strobe", out_strobe, eo);
        if (eo != 0) check("out_data", out_data, ed);
        check("overrun", overrun, m_ovr);
        check("sync_err", sync_err, 0);
        for (int k = 0; k < NCH; k++) begin
            if (out_strobe[k]) begin
                out_cnt[k]++;
                if (start_q[k].size() > 0) begin
                    int s, w;
                    s = start_q[k].pop_front();
                    w = (cyc - 4) - (s + 1);
                    if (w > max_wait) max_wait = w;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!reset_n) model_reset();
        else if (model_on) model_edge();
        #1;
        if (model_on) compare_all();
    endtask

    task automatic rand_data();
        for (int k = 0; k < NCH; k++) begin
            ch_i[k*DS +: DS] = DS'($urandom);
            ch_q[k*DS +: DS] = DS'($urandom);
        end
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        model_reset();
        step();
        step();
        reset_n = 1'b1;
    endtask

    logic [NCH-1:0] any_out;

    initial begin
        reset_n   = 1'b0;
        ch_strobe = '0;
        ch_i      = '0;
        ch_q      = '0;
        flag_clr  = 1'b0;
        inj_en    = 1'b0;
        drop_en   = 1'b0;
        model_on  = 1;
        max_wait  = 0;
        for (int k = 0; k < NCH; k++) begin
            grants[k]  = 0;
            out_cnt[k] = 0;
        end
        model_reset();

        // Reset values
        repeat (3) step();
        check("reset_outputs", {dm_strobe, dm_i, dm_q, out_strobe, out_data, overrun, sync_err}, 64'd0);
        reset_n = 1'b1;
        while (cyc < 10) step();

        // Single sample on channel 2
        ch_i[2*DS +: DS] = 16'h0300;
        ch_q[2*DS +: DS] = 16'h0400;
        ch_strobe = 4'b0100;
        step();
        ch_strobe = '0;
        step();
        check("single_dm_strobe", dm_strobe, 1);
        check("single_dm_iq", {dm_i, dm_q}, 32'h0300_0400);
        repeat (4) step();
        check("single_out_strobe", out_strobe, 4'b0100);
        check("single_out_data", out_data, 16'h0500);
        repeat (3) step();

        // Simultaneous strobes with rr_ptr at 0
        reset_pulse();
        rand_data();
        ch_strobe = '1;
        step();
        ch_strobe = '0;
        repeat (4) step();
        for (int j = 0; j < NCH; j++) begin
            step();
            check("simul_order", out_strobe, NCH'(1) << j);
        end
        check("simul_overrun", overrun, 0);

        // Overrun: channels 0, 1, 3 strobing every cycle
        for (int c = 0; c < 30; c++) begin
            rand_data();
            ch_strobe = 4'b1011;
            step();
        end
        ch_strobe = '0;
        repeat (10) step();
        check("ovr1_set", overrun[1], 1);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("ovr_clear", overrun, 0);

        // Fairness under random traffic
        for (int k = 0; k < NCH; k++) begin
            grants[k]  = 0;
            out_cnt[k] = 0;
        end
        max_wait = 0;
        for (int c = 0; c < 10000; c++) begin
            rand_data();
            ch_strobe = NCH'($urandom) & NCH'($urandom);
            flag_clr  = ($urandom_range(0, 63) == 0);
            step();
        end
        ch_strobe = '0;
        flag_clr  = 1'b0;
        repeat (10) step();
        for (int k = 0; k < NCH; k++) check("fair_count", out_cnt[k], grants[k]);
        check("fair_max_wait", max_wait <= NCH - 1, 1);
        check("fair_sync_err", sync_err, 0);

        // Reset in the middle of a burst
        rand_data();
        ch_strobe = '1;
        step();
        ch_strobe = '0;
        repeat (6) step();
        reset_n = 1'b0;
        #1;
        check("rst_async", {dm_strobe, dm_i, dm_q, out_strobe, out_data, overrun, sync_err}, 64'd0);
        model_reset();
        step();
        step();
        reset_n = 1'b1;
        any_out = '0;
        repeat (12) begin
            step();
            any_out = any_out | out_strobe;
        end
        check("rst_no_out", any_out, 0);

        // Sync errors: spurious strobe, then a dropped strobe
        model_on = 0;
        reset_pulse();
        step();
        inj_en = 1'b1;
        step();
        inj_en = 1'b0;
        check("sync_inj_err", sync_err, 1);
        any_out = out_strobe;
        repeat (4) begin
            step();
            any_out = any_out | out_strobe;
        end
        check("sync_inj_out", any_out, 0);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("sync_clear", sync_err, 0);
        ch_i[0 +: DS] = 16'h0123;
        ch_q[0 +: DS] = 16'h0456;
        ch_strobe = 4'b0001;
        step();
        ch_strobe = '0;
        drop_en = 1'b1;
        any_out = '0;
        repeat (8) begin
            step();
            any_out = any_out | out_strobe;
        end
        drop_en = 1'b0;
        check("sync_drop_err", sync_err, 1);
        check("sync_drop_out", any_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
